computational_unit_p: RTL and testbench
=======================================

COMPUTATIONAL_UNIT_P -- requirements
Module: computational_unit_p

Interface
REQ-001 SHALL have parameter DATA_W, default 4, datapath width in bits (legal 4..16).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port sync_reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port nibble_ir  in  4  ALU opcode and immediate source.
REQ-005 SHALL have port source_sel  in  4  data_bus source select.
REQ-006 SHALL have port reg_en  in  9  load enables: [0]x0 [1]x1 [2]y0 [3]y1 [4]r/ALU start [5]m [6]i [7]unused [8]o_reg.
REQ-007 SHALL have ports x_sel, y_sel, i_sel  in  1 each  operand and index-source selects.
REQ-008 SHALL have ports dm, i_pins  in  DATA_W  data memory and pin inputs.
REQ-009 SHALL have port data_bus  out  DATA_W  selected bus value.
REQ-010 SHALL have ports x0, x1, y0, y1, r, m, i, o_reg  out  DATA_W  register contents.
REQ-011 SHALL have ports r_eq_0, zero_flag, carry_flag, busy  out  1  flags and multiply-busy.

Function
REQ-012 data_bus SHALL be combinational: source_sel 0..9 = x0,x1,y0,y1,r,m,i,dm,zero-extended nibble_ir,i_pins; 10..15 = 0.
REQ-013 x0,x1,y0,y1,m,o_reg SHALL load data_bus on the edge when their reg_en bit is 1, else hold; loads proceed while busy.
REQ-014 i SHALL load (m + i) mod 2^DATA_W when i_sel=1, else data_bus, when reg_en[6]=1.
REQ-015 Operand x SHALL be x1 when x_sel=1 else x0; y SHALL be y1 when y_sel=1 else y0.
REQ-016 Opcodes: 0000 -x (two's complement); 0111 ~x; 1000,1111 no-op; {b,001} x-y; {b,010} x+y; {b,011} product high half; {b,100} product low half; {b,101} x^y; {b,110} x&y, b don't-care; all results mod 2^DATA_W.
REQ-017 Single-cycle ops SHALL write r on the edge where reg_en[4]=1 and busy=0; r_eq_0 written simultaneously with (new r == 0).
REQ-018 carry_flag SHALL update only on add (carry out) and subtract (1 when x<y unsigned, borrow); other ops hold it.
REQ-019 No-op SHALL hold r, r_eq_0, carry_flag.
REQ-020 zero_flag SHALL equal r_eq_0 (registered, no combinational path from ALU).
REQ-021 Multiply SHALL use a two-state FSM IDLE/MUL with shift-add over DATA_W iterations and a 2*DATA_W-bit accumulator.
REQ-022 IDLE->MUL on edge with reg_en[4]=1, multiply opcode, busy=0; x, y and half-select latched on that edge.
REQ-023 In MUL one partial product per edge; after DATA_W edges in MUL, r and r_eq_0 SHALL load the selected half and FSM SHALL return to IDLE.
REQ-024 busy SHALL be 1 exactly while in MUL (DATA_W cycles); r valid, busy 0 after edge DATA_W counted from start edge.
REQ-025 reg_en[4] while busy SHALL be ignored (no r write, no restart, no flag change).
REQ-026 Operand register changes during MUL SHALL not affect the result.

Reset
REQ-027 sync_reset=1 at an edge SHALL clear x0,x1,y0,y1,r,m,i,o_reg,carry_flag to 0, set r_eq_0=1, FSM to IDLE, busy=0, abort any multiply; reset dominates all enables.

Configuration
REQ-028 Macro CU_SEQ_MULT_EN defined: multiply per REQ-021..026.
REQ-029 CU_SEQ_MULT_EN undefined: no FSM/accumulator; multiply opcodes act as no-op; busy tied 0.

Verification (DATA_W=4)
REQ-030 x0=5, y0=3, op 0010, reg_en[4] -> next edge r=8, carry_flag=0, r_eq_0=0.
REQ-031 x0=9, y0=7, op 0010 -> r=0, carry_flag=1, zero_flag=1; then op 0001 x0=2,y0=3 -> r=0xF, carry_flag=1.
REQ-032 x0=7, y0=6, op 0100 -> busy=1 4 cycles, r=0xA; op 0011 -> r=0x2; x0 changed mid-multiply -> result unchanged; reg_en[4] while busy ignored.
REQ-033 multiply started, sync_reset on 2nd busy cycle -> next edge busy=0, r=0, r_eq_0=1, no later r write.
REQ-034 m=3, i=0xE, i_sel=1, reg_en[6] -> i=0x1; source_sel=8, nibble_ir=0xC, reg_en[8] -> o_reg=0xC.
REQ-035 CU_SEQ_MULT_EN undefined, r=4, op 0100 -> r stays 4, busy stays 0.

Source files
------------

// File: rtl/computational_unit_p.sv
// computational_unit_p
//   Register file, bus multiplexer and ALU for a small nibble-coded processor.
//   data_bus selects one of the registers, data memory, the immediate nibble or
//   the input pins.  The ALU writes r, r_eq_0 (mirrored on zero_flag) and
//   carry_flag.
//
//   Build option: define CU_SEQ_MULT_EN to include a shift-add multiplier
//   (opcodes x011 = high half, x100 = low half).  It runs for DATA_W cycles
//   with busy high.  Without the macro, the multiply opcodes are no-ops and
//   busy is tied low.
//
// Ports
//   clk, sync_reset          clock, synchronous active-high reset
//   nibble_ir[3:0]           ALU opcode / immediate value
//   source_sel[3:0]          data_bus source select
//   reg_en[8:0]              load enables: x0,x1,y0,y1,r(ALU),m,i,-,o_reg
//   x_sel, y_sel, i_sel      operand selects, index increment select
//   dm, i_pins               data memory / pin inputs
//   data_bus                 selected bus value
//   x0,x1,y0,y1,r,m,i,o_reg  register contents
//   r_eq_0, zero_flag        result-is-zero flag (registered)
//   carry_flag               add carry / subtract borrow
//   busy                     multiply in progress
module computational_unit_p #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic [3:0]        nibble_ir,
  input  logic [3:0]        source_sel,
  input  logic [8:0]        reg_en,
  input  logic              x_sel,
  input  logic              y_sel,
  input  logic              i_sel,
  input  logic [DATA_W-1:0] dm,
  input  logic [DATA_W-1:0] i_pins,
  output logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] o_reg,
  output logic              r_eq_0,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              busy
);

  logic [DATA_W-1:0] nib_ext;
  logic [DATA_W-1:0] x, y;
  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_wr;
  logic              carry_wr;
  logic              carry_val;
  logic              is_mul;
  logic              mul_hi;
  logic              do_single;

  always_comb begin
    nib_ext      = '0;
    nib_ext[3:0] = nibble_ir;
  end

  always_comb begin
    case (source_sel)
      4'd0:    data_bus = x0;
      4'd1:    data_bus = x1;
      4'd2:    data_bus = y0;
      4'd3:    data_bus = y1;
      4'd4:    data_bus = r;
      4'd5:    data_bus = m;
      4'd6:    data_bus = i;
      4'd7:    data_bus = dm;
      4'd8:    data_bus = nib_ext;
      4'd9:    data_bus = i_pins;
      default: data_bus = '0;
    endcase
  end

  assign x = x_sel ? x1 : x0;
  assign y = y_sel ? y1 : y0;

  // Single-cycle ALU decode; multiply opcodes are only flagged here and
  // handled by the sequential multiplier.
  always_comb begin
    sum       = {1'b0, x} + {1'b0, y};
    diff      = {1'b0, x} - {1'b0, y};
    alu_res   = r;
    alu_wr    = 1'b0;
    carry_wr  = 1'b0;
    carry_val = carry_flag;
    is_mul    = 1'b0;
    mul_hi    = 1'b0;
    if (nibble_ir == 4'b0000) begin
      alu_res = -x;
      alu_wr  = 1'b1;
    end else if (nibble_ir == 4'b0111) begin
      alu_res = ~x;
      alu_wr  = 1'b1;
    end else if (nibble_ir == 4'b1000 || nibble_ir == 4'b1111) begin
      alu_wr = 1'b0;
    end else begin
      case (nibble_ir[2:0])
        3'b001: begin
          alu_res   = diff[DATA_W-1:0];
          alu_wr    = 1'b1;
          carry_wr  = 1'b1;
          carry_val = diff[DATA_W];
        end
        3'b010: begin
          alu_res   = sum[DATA_W-1:0];
          alu_wr    = 1'b1;
          carry_wr  = 1'b1;
          carry_val = sum[DATA_W];
        end
        3'b011: begin
          is_mul = 1'b1;
          mul_hi = 1'b1;
        end
        3'b100: is_mul = 1'b1;
        3'b101: begin
          alu_res = x ^ y;
          alu_wr  = 1'b1;
        end
        3'b110: begin
          alu_res = x & y;
          alu_wr  = 1'b1;
        end
        default: alu_wr = 1'b0;
      endcase
    end
  end

  assign do_single = reg_en[4] & ~busy & alu_wr;
  assign zero_flag = r_eq_0;

`ifdef CU_SEQ_MULT_EN
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MUL  = 1'b1;

  logic                state;
  logic [CW-1:0]       cnt;
  logic [2*DATA_W-1:0] acc, mcand, acc_next;
  logic [DATA_W-1:0]   mplier;
  logic                hi_sel;
  logic                mul_start;
  logic                mul_last;
  logic [DATA_W-1:0]   mul_res;
  logic                unused_bits;

  assign busy      = (state == ST_MUL);
  assign mul_start = reg_en[4] & is_mul & ~busy;
  assign mul_last  = busy & (cnt == CW'(DATA_W - 1));
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign mul_res   = hi_sel ? acc_next[2*DATA_W-1:DATA_W] : acc_next[DATA_W-1:0];
  assign unused_bits = reg_en[7];
`else
  logic unused_bits;
  assign busy        = 1'b0;
  assign unused_bits = ^{reg_en[7], is_mul, mul_hi};
`endif

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      x0         <= '0;
      x1         <= '0;
      y0         <= '0;
      y1         <= '0;
      r          <= '0;
      m          <= '0;
      i          <= '0;
      o_reg      <= '0;
      carry_flag <= 1'b0;
      r_eq_0     <= 1'b1;
`ifdef CU_SEQ_MULT_EN
      state      <= ST_IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      hi_sel     <= 1'b0;
`endif
    end else begin
      if (reg_en[0]) x0    <= data_bus;
      if (reg_en[1]) x1    <= data_bus;
      if (reg_en[2]) y0    <= data_bus;
      if (reg_en[3]) y1    <= data_bus;
      if (reg_en[5]) m     <= data_bus;
      if (reg_en[8]) o_reg <= data_bus;
      if (reg_en[6]) i     <= i_sel ? (m + i) : data_bus;

      if (do_single) begin
        r      <= alu_res;
        r_eq_0 <= (alu_res == '0);
        if (carry_wr) carry_flag <= carry_val;
      end

`ifdef CU_SEQ_MULT_EN
      // Operands are copied into private shift registers at start, so later
      // loads of x0..y1 cannot disturb the product.
      if (mul_start) begin
        state  <= ST_MUL;
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{DATA_W{1'b0}}, x};
        mplier <= y;
        hi_sel <= mul_hi;
      end else if (busy) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (mul_last) begin
          state  <= ST_IDLE;
          r      <= mul_res;
          r_eq_0 <= (mul_res == '0);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_computational_unit_p.sv
// Directed self-checking bench for computational_unit_p at DATA_W=4.
module tb_computational_unit_p;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         sync_reset;
  logic [3:0]   nibble_ir, source_sel;
  logic [8:0]   reg_en;
  logic         x_sel, y_sel, i_sel;
  logic [W-1:0] dm, i_pins;
  logic [W-1:0] data_bus, x0, x1, y0, y1, r, m, i, o_reg;
  logic         r_eq_0, zero_flag, carry_flag, busy;

  int n_checks = 0;
  int n_pass   = 0;

  computational_unit_p #(.DATA_W(W)) dut (
    .clk(clk), .sync_reset(sync_reset), .nibble_ir(nibble_ir),
    .source_sel(source_sel), .reg_en(reg_en), .x_sel(x_sel), .y_sel(y_sel),
    .i_sel(i_sel), .dm(dm), .i_pins(i_pins), .data_bus(data_bus),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .r(r), .m(m), .i(i), .o_reg(o_reg),
    .r_eq_0(r_eq_0), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] en, input logic [3:0] v);
    source_sel = 4'd8;
    nibble_ir  = v;
    reg_en     = en;
    step();
    reg_en = '0;
  endtask

  task automatic alu(input logic [3:0] op, input logic xs, input logic ys);
    nibble_ir = op;
    x_sel     = xs;
    y_sel     = ys;
    reg_en    = 9'h010;
    step();
    reg_en = '0;
  endtask

  initial begin
    sync_reset = 1'b1;
    nibble_ir  = '0;
    source_sel = '0;
    reg_en     = '0;
    x_sel = 1'b0; y_sel = 1'b0; i_sel = 1'b0;
    dm = 4'h5; i_pins = 4'h7;
    step();
    step();
    check("rst_x0", x0, 0);
    check("rst_r", r, 0);
    check("rst_req0", r_eq_0, 1);
    check("rst_zf", zero_flag, 1);
    check("rst_cf", carry_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_i", i, 0);
    check("rst_oreg", o_reg, 0);
    sync_reset = 1'b0;

    // add 5+3
    load(9'h001, 4'h5);
    load(9'h004, 4'h3);
    check("ld_x0", x0, 5);
    check("ld_y0", y0, 3);
    alu(4'b0010, 0, 0);
    check("add_r", r, 8);
    check("add_cf", carry_flag, 0);
    check("add_req0", r_eq_0, 0);

    // add 9+7 wraps to 0 with carry
    load(9'h001, 4'h9);
    load(9'h004, 4'h7);
    alu(4'b0010, 0, 0);
    check("addc_r", r, 0);
    check("addc_cf", carry_flag, 1);
    check("addc_zf", zero_flag, 1);

    // subtract 2-3 borrows
    load(9'h001, 4'h2);
    load(9'h004, 4'h3);
    alu(4'b0001, 0, 0);
    check("sub_r", r, 4'hF);
    check("sub_cf", carry_flag, 1);
    check("sub_req0", r_eq_0, 0);

    // logic ops on x1/y1, carry must hold
    load(9'h002, 4'hC);
    load(9'h008, 4'hA);
    alu(4'b0101, 1, 1);
    check("xor_r", r, 4'h6);
    check("xor_cf_hold", carry_flag, 1);
    alu(4'b1110, 1, 1);
    check("and_r", r, 4'h8);
    alu(4'b0111, 1, 0);
    check("not_r", r, 4'h3);
    alu(4'b0000, 0, 0);
    check("neg_r", r, 4'hE);
    alu(4'b1000, 0, 0);
    check("nop8_r", r, 4'hE);
    alu(4'b1111, 0, 0);
    check("nopF_r", r, 4'hE);
    check("nop_cf", carry_flag, 1);

    // reg_en[4] low: no write
    nibble_ir = 4'b0010; reg_en = '0;
    step();
    check("noen_r", r, 4'hE);
    alu(4'b1010, 0, 0);
    check("add2_r", r, 4'h5);
    check("add2_cf", carry_flag, 0);

    // index register and output register
    load(9'h020, 4'h3);
    load(9'h040, 4'hE);
    check("i_load", i, 4'hE);
    i_sel = 1'b1;
    reg_en = 9'h040;
    step();
    reg_en = '0;
    i_sel = 1'b0;
    check("i_inc", i, 4'h1);
    load(9'h100, 4'hC);
    check("oreg", o_reg, 4'hC);

    // bus sources
    source_sel = 4'd9; #1; check("bus_pins", data_bus, 4'h7);
    source_sel = 4'd7; #1; check("bus_dm", data_bus, 4'h5);
    source_sel = 4'd12; #1; check("bus_zero", data_bus, 0);
    source_sel = 4'd0; #1; check("bus_x0", data_bus, 4'h2);
    source_sel = 4'd5; #1; check("bus_m", data_bus, 4'h3);

`ifdef CU_SEQ_MULT_EN
    // 7*6 = 0x2A
    load(9'h001, 4'h7);
    load(9'h004, 4'h6);
    alu(4'b0100, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("mul_busy", busy, 1);
      if (k == 1) begin
        source_sel = 4'd8; nibble_ir = 4'h1; reg_en = 9'h001;
      end else if (k == 2) begin
        nibble_ir = 4'b0010; reg_en = 9'h010;
      end
      step();
      reg_en = '0;
    end
    check("mul_done_busy", busy, 0);
    check("mul_lo_r", r, 4'hA);
    check("mul_req0", r_eq_0, 0);
    check("mul_x0_loaded", x0, 4'h1);
    load(9'h001, 4'h7);
    alu(4'b1011, 0, 0);
    repeat (4) step();
    check("mul_hi_r", r, 4'h2);
    check("mul_hi_busy", busy, 0);

    // reset during multiply
    alu(4'b0100, 0, 0);
    step();
    check("mulrst_busy_pre", busy, 1);
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    check("mulrst_busy", busy, 0);
    check("mulrst_r", r, 0);
    check("mulrst_req0", r_eq_0, 1);
    repeat (5) step();
    check("mulrst_r_later", r, 0);
    check("mulrst_busy_later", busy, 0);
`else
    // multiply opcodes are no-ops without the multiplier
    load(9'h001, 4'h2);
    load(9'h004, 4'h2);
    alu(4'b0010, 0, 0);
    check("pre_mul_r", r, 4'h4);
    alu(4'b0100, 0, 0);
    check("nomul_busy", busy, 0);
    check("nomul_r", r, 4'h4);
    alu(4'b0011, 0, 0);
    repeat (4) step();
    check("nomul_hi_r", r, 4'h4);
    check("nomul_busy2", busy, 0);
    check("nomul_cf", carry_flag, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
